// File: rtl/system_ram_pipe.sv
// system_ram_pipe: Avalon-MM slave RAM with byte enables, optional zero-fill
// after reset, and a fully pipelined read path of 1 or 2 clock-enabled cycles.
// Addresses at or beyond DEPTH ignore writes and read back as zero.
module system_ram_pipe #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 11,
   parameter int DEPTH        = 2048,
   parameter int READ_LATENCY = 1,
   parameter int INIT_ZERO    = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [ADDR_WIDTH-1:0]   address,
   input  logic [DATA_WIDTH/8-1:0] byteenable,
   input  logic                    chipselect,
   input  logic                    read,
   input  logic                    write,
   input  logic [DATA_WIDTH-1:0]   writedata,
   input  logic                    clken,
   input  logic                    reset_req,
   output logic [DATA_WIDTH-1:0]   readdata,
   output logic                    readdatavalid,
   output logic                    waitrequest,
   output logic                    init_done
);

   localparam int NBYTES = DATA_WIDTH / 8;
   localparam logic [ADDR_WIDTH:0] DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] LAST_ADDR = (ADDR_WIDTH + 1)'(DEPTH - 1);

   typedef enum logic {INIT, READY} state_t;

   state_t                  state, state_nxt;
   logic [ADDR_WIDTH:0]     fill_cnt, fill_cnt_nxt;
   logic [DATA_WIDTH-1:0]   mem [DEPTH];

   logic                    clocken;
   logic                    in_range;
   logic                    wr_acc;
   logic                    rd_acc;
   logic                    fill_we;
   logic [DATA_WIDTH-1:0]   rd_word;

   logic                    stg_v;
   logic [DATA_WIDTH-1:0]   stg_d;
   logic                    out_v;

   assign clocken  = clken & ~reset_req;
   assign in_range = {1'b0, address} < DEPTH_W;
   assign wr_acc   = chipselect & write & ~waitrequest & clocken;
   assign rd_acc   = chipselect & read & ~write & ~waitrequest & clocken;
   assign fill_we  = (state == INIT) && (INIT_ZERO != 0) && clocken;
   assign rd_word  = in_range ? mem[address] : '0;

   // State and fill-counter register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= INIT;
         fill_cnt <= '0;
      end else begin
         state    <= state_nxt;
         fill_cnt <= fill_cnt_nxt;
      end
   end

   // Next state: zero-fill one word per enabled cycle, READY after the last word
   always_comb begin
      state_nxt    = state;
      fill_cnt_nxt = fill_cnt;
      waitrequest  = (state == INIT);
      init_done    = (state == READY);
      case (state)
         INIT: begin
            if (INIT_ZERO == 0) begin
               state_nxt = READY;
            end else if (clocken) begin
               fill_cnt_nxt = fill_cnt + 1'b1;
               if (fill_cnt == LAST_ADDR) state_nxt = READY;
            end
         end
         READY: begin
         end
         default: state_nxt = INIT;
      endcase
   end

   // Array update: fill words during INIT, byte-lane merges for in-range writes
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (fill_we) begin
            mem[fill_cnt[ADDR_WIDTH-1:0]] <= '0;
         end else if (wr_acc && in_range) begin
            for (int unsigned i = 0; i < NBYTES; i++) begin
               if (byteenable[i]) mem[address][8*i +: 8] <= writedata[8*i +: 8];
            end
         end
      end
   end

   // Read pipeline: advances only on enabled cycles; readdata reloads only on a valid slot
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stg_v    <= 1'b0;
         stg_d    <= '0;
         out_v    <= 1'b0;
         readdata <= '0;
      end else if (clocken) begin
         if (READ_LATENCY == 2) begin
            stg_v <= rd_acc;
            if (rd_acc) stg_d <= rd_word;
            out_v <= stg_v;
            if (stg_v) readdata <= stg_d;
         end else begin
            out_v <= rd_acc;
            if (rd_acc) readdata <= rd_word;
         end
      end
   end

   // A stalled result stays pending and is shown only on an enabled cycle
   assign readdatavalid = out_v & clocken;

endmodule

// File: tb/tb_system_ram_pipe.sv
// Bench for system_ram_pipe: three instances (16 words / latency 1,
// 16 words / latency 2, 1000 words / latency 1) share one command stream and
// are compared every cycle against a transaction-level model.
module tb_system_ram_pipe;

   localparam int NI = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic        chipselect, read, write, clken, reset_req;
   logic [9:0]  address;
   logic [3:0]  byteenable;
   logic [31:0] writedata;

   logic [31:0] rdata [NI];
   logic        rdv   [NI];
   logic        wreq  [NI];
   logic        idone [NI];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   system_ram_pipe #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(16), .READ_LATENCY(1), .INIT_ZERO(1)) dut_a (
      .clk(clk), .reset(reset), .address(address[4:0]), .byteenable(byteenable),
      .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
      .clken(clken), .reset_req(reset_req), .readdata(rdata[0]), .readdatavalid(rdv[0]),
      .waitrequest(wreq[0]), .init_done(idone[0]));

   system_ram_pipe #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(16), .READ_LATENCY(2), .INIT_ZERO(1)) dut_b (
      .clk(clk), .reset(reset), .address(address[4:0]), .byteenable(byteenable),
      .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
      .clken(clken), .reset_req(reset_req), .readdata(rdata[1]), .readdatavalid(rdv[1]),
      .waitrequest(wreq[1]), .init_done(idone[1]));

   system_ram_pipe #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .DEPTH(1000), .READ_LATENCY(1), .INIT_ZERO(1)) dut_c (
      .clk(clk), .reset(reset), .address(address), .byteenable(byteenable),
      .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
      .clken(clken), .reset_req(reset_req), .readdata(rdata[2]), .readdatavalid(rdv[2]),
      .waitrequest(wreq[2]), .init_done(idone[2]));

   // ---------------- reference model ----------------
   typedef struct {
      int          inst;
      int          due;
      logic [31:0] data;
   } rd_t;

   logic [31:0] mm [NI][1024];
   int          fill   [NI];
   int          ce_cnt [NI];
   logic [31:0] last   [NI];
   rd_t         pq[$];

   function automatic int depth_of(input int k);
      return (k == 2) ? 1000 : 16;
   endfunction

   function automatic int lat_of(input int k);
      return (k == 1) ? 2 : 1;
   endfunction

   function automatic int addr_of(input int k);
      return (k == 2) ? int'(address) : int'(address[4:0]);
   endfunction

   function automatic int head_of(input int k);
      for (int i = 0; i < pq.size(); i++) if (pq[i].inst == k) return i;
      return -1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_cycle();
      bit ce, rdy, ev;
      int h;
      ce = clken & ~reset_req;
      for (int k = 0; k < NI; k++) begin
         if (reset) begin
            chk($sformatf("rst_wreq%0d", k), 32'(wreq[k]), 32'd1);
            chk($sformatf("rst_idone%0d", k), 32'(idone[k]), 32'd0);
            chk($sformatf("rst_rdv%0d", k), 32'(rdv[k]), 32'd0);
            chk($sformatf("rst_rdata%0d", k), rdata[k], 32'd0);
         end else begin
            rdy = (fill[k] == depth_of(k));
            h   = head_of(k);
            ev  = ce && (h >= 0) && (pq[h].due == ce_cnt[k]);
            chk($sformatf("wreq%0d", k), 32'(wreq[k]), 32'(!rdy));
            chk($sformatf("idone%0d", k), 32'(idone[k]), 32'(rdy));
            chk($sformatf("rdv%0d", k), 32'(rdv[k]), 32'(ev));
            if (ev)          chk($sformatf("rdata%0d", k), rdata[k], pq[h].data);
            else if (h < 0)  chk($sformatf("hold%0d", k), rdata[k], last[k]);
         end
      end
   endtask

   task automatic update_model();
      bit ce;
      int h, a;
      rd_t r;
      if (reset) begin
         for (int k = 0; k < NI; k++) begin
            fill[k] = 0; ce_cnt[k] = 0; last[k] = '0;
         end
         pq.delete();
         return;
      end
      ce = clken & ~reset_req;
      if (!ce) return;
      for (int k = 0; k < NI; k++) begin
         if (fill[k] != depth_of(k)) begin
            mm[k][fill[k]] = '0;
            fill[k]++;
            continue;
         end
         h = head_of(k);
         if (h >= 0 && pq[h].due == ce_cnt[k]) begin
            last[k] = pq[h].data;
            pq.delete(h);
         end
         a = addr_of(k);
         if (chipselect && write) begin
            if (a < depth_of(k))
               for (int b = 0; b < 4; b++)
                  if (byteenable[b]) mm[k][a][8*b +: 8] = writedata[8*b +: 8];
         end else if (chipselect && read) begin
            r.inst = k;
            r.due  = ce_cnt[k] + lat_of(k);
            r.data = (a < depth_of(k)) ? mm[k][a] : 32'd0;
            pq.push_back(r);
         end
         ce_cnt[k]++;
      end
   endtask

   task automatic tick();
      @(negedge clk);
      check_cycle();
      @(posedge clk);
      update_model();
      #1;
   endtask

   task automatic idle();
      chipselect = 1'b0; read = 1'b0; write = 1'b0;
   endtask

   task automatic cmd(input bit rd, input bit wr, input logic [9:0] a,
                      input logic [3:0] be, input logic [31:0] wd);
      chipselect = 1'b1; read = rd; write = wr;
      address = a; byteenable = be; writedata = wd;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int wcnt, rise;
      reset = 1'b1; clken = 1'b1; reset_req = 1'b0;
      address = '0; byteenable = '0; writedata = '0;
      idle();
      for (int k = 0; k < NI; k++) begin
         fill[k] = 0; ce_cnt[k] = 0; last[k] = '0;
      end
      @(posedge clk); #1;
      repeat (3) tick();

      // Fill length on the 16-word instance: 16 busy cycles, ready on cycle 17
      reset = 1'b0;
      wcnt = 0; rise = 0;
      for (int c = 1; c <= 20; c++) begin
         #2;
         if (wreq[0]) wcnt++;
         if (idone[0] && rise == 0) rise = c;
         tick();
      end
      chk("fill_wait_cycles", 32'(wcnt), 32'd16);
      chk("init_done_cycle", 32'(rise), 32'd17);

      // Reset at fill address 9 restarts the fill from 0
      reset = 1'b1; tick(); tick();
      reset = 1'b0;
      repeat (9) tick();
      reset = 1'b1; tick(); tick();
      reset = 1'b0;
      wcnt = 0;
      for (int c = 1; c <= 20; c++) begin
         #2;
         if (wreq[0]) wcnt++;
         tick();
      end
      chk("refill_wait_cycles", 32'(wcnt), 32'd16);

      // Reads of a freshly filled small array, while the large one still fills
      for (int i = 0; i < 16; i++) begin
         cmd(1'b1, 1'b0, 10'(i), 4'h0, 32'h0);
         tick();
      end
      idle();

      // Let the 1000-word instance finish under an irregular clock enable
      for (int c = 0; c < 1500; c++) begin
         clken = ($urandom_range(0, 3) != 0);
         tick();
      end
      clken = 1'b1;
      tick(); tick();
      chk("large_ready", 32'(idone[2]), 32'd1);

      // Byte-lane merge
      cmd(1'b0, 1'b1, 10'd5, 4'hF, 32'hAABBCCDD); tick();
      cmd(1'b0, 1'b1, 10'd5, 4'h5, 32'h11223344); tick();
      cmd(1'b1, 1'b0, 10'd5, 4'h0, 32'h0);        tick();
      idle(); #1;
      chk("merge_valid", 32'(rdv[0]), 32'd1);
      chk("merge_data", rdata[0], 32'hAA22CC44);
      tick(); tick();

      // Read right after a partial write returns the merged word
      cmd(1'b0, 1'b1, 10'd7, 4'hF, 32'hDEADBEEF); tick();
      cmd(1'b0, 1'b1, 10'd7, 4'h3, 32'h00001234); tick();
      cmd(1'b1, 1'b0, 10'd7, 4'h0, 32'h0);        tick();
      idle(); #1;
      chk("raw_data", rdata[0], 32'hDEAD1234);
      tick(); tick();

      // Read and write together: write only, no data return
      cmd(1'b1, 1'b1, 10'd9, 4'hF, 32'h00000055); tick();
      idle(); #1;
      chk("rw_no_valid", 32'(rdv[0]), 32'd0);
      tick(); tick(); tick();

      // Back-to-back reads through the two-cycle pipeline
      cmd(1'b0, 1'b1, 10'd1, 4'hF, 32'h01010101); tick();
      cmd(1'b0, 1'b1, 10'd2, 4'hF, 32'h02020202); tick();
      cmd(1'b0, 1'b1, 10'd3, 4'hF, 32'h03030303); tick();
      cmd(1'b1, 1'b0, 10'd1, 4'h0, 32'h0); tick();
      cmd(1'b1, 1'b0, 10'd2, 4'h0, 32'h0); #1;
      chk("lat2_gap", 32'(rdv[1]), 32'd0);
      tick();
      cmd(1'b1, 1'b0, 10'd3, 4'h0, 32'h0); #1;
      chk("lat2_v1", 32'(rdv[1]), 32'd1);
      chk("lat2_d1", rdata[1], 32'h01010101);
      tick();
      idle(); #1;
      chk("lat2_d2", rdata[1], 32'h02020202);
      tick(); #1;
      chk("lat2_d3", rdata[1], 32'h03030303);
      tick(); #1;
      chk("lat2_end", 32'(rdv[1]), 32'd0);
      tick();

      // Stall after a read: clken low, then reset_req high, 3 cycles each
      for (int pass = 0; pass < 2; pass++) begin
         cmd(1'b1, 1'b0, 10'd5, 4'h0, 32'h0); tick();
         idle();
         if (pass == 0) clken = 1'b0; else reset_req = 1'b1;
         #1;
         chk($sformatf("stall%0d_quiet", pass), 32'(rdv[0]), 32'd0);
         tick(); tick(); tick();
         clken = 1'b1; reset_req = 1'b0; #1;
         chk($sformatf("stall%0d_valid", pass), 32'(rdv[0]), 32'd1);
         chk($sformatf("stall%0d_data", pass), rdata[0], 32'hAA22CC44);
         tick(); tick();
      end

      // Beyond the 1000-word boundary
      cmd(1'b0, 1'b1, 10'd1020, 4'hF, 32'hFFFFFFFF); tick();
      cmd(1'b1, 1'b0, 10'd1020, 4'h0, 32'h0);        tick();
      idle(); #1;
      chk("oob_valid", 32'(rdv[2]), 32'd1);
      chk("oob_data", rdata[2], 32'd0);
      tick(); tick();

      // Random traffic
      for (int c = 0; c < 600; c++) begin
         chipselect = ($urandom_range(0, 7) != 0);
         read       = $urandom_range(0, 1);
         write      = ($urandom_range(0, 2) == 0);
         address    = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023))
                                                  : 10'($urandom_range(0, 17));
         byteenable = 4'($urandom_range(0, 15));
         writedata  = $urandom;
         clken      = ($urandom_range(0, 6) != 0);
         reset_req  = ($urandom_range(0, 9) == 0);
         tick();
      end
      idle(); clken = 1'b1; reset_req = 1'b0;
      repeat (4) tick();

      // Reset with reads in flight: nothing may come out afterwards
      cmd(1'b1, 1'b0, 10'd5, 4'h0, 32'h0); tick();
      reset = 1'b1; idle(); tick();
      reset = 1'b0;
      repeat (4) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/system_ram_pipe.md
SYSTEM_RAM_PIPE -- requirements
Module: system_ram_pipe

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the word width; it is a multiple of 8, from 8 to 128.
REQ-002 Parameter ADDR_WIDTH, default 11, SHALL set the word-address width.
REQ-003 Parameter DEPTH, default 2048, SHALL set the number of words; DEPTH <= 2^ADDR_WIDTH.
REQ-004 Parameter READ_LATENCY, default 1, SHALL set the cycles from read acceptance to readdatavalid; the legal values are 1 and 2.
REQ-005 Parameter INIT_ZERO, default 1, SHALL select whether the block zero-fills the whole array after reset (1) or skips the fill (0).
REQ-006 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-007 reset  input  1  SHALL be asynchronous, active-high reset.
REQ-008 address  input  ADDR_WIDTH  SHALL carry the word address.
REQ-009 byteenable  input  DATA_WIDTH/8  SHALL carry the per-byte write lane enables.
REQ-010 chipselect, read, write  input  1 each  SHALL be the Avalon-MM slave select and command strobes.
REQ-011 writedata  input  DATA_WIDTH  SHALL carry the write data.
REQ-012 clken  input  1  SHALL be the clock enable.
REQ-013 reset_req  input  1  SHALL be the reset-request signal; clocken = clken & ~reset_req.
REQ-014 readdata  output  DATA_WIDTH  SHALL carry the registered read data.
REQ-015 readdatavalid  output  1  SHALL pulse for one cycle per returned read.
REQ-016 waitrequest  output  1  SHALL be high while commands cannot be accepted.
REQ-017 init_done  output  1  SHALL be high once the array is ready.

Function
REQ-018 The FSM SHALL have exactly two states, INIT and READY; waitrequest SHALL equal (state==INIT), and init_done SHALL equal (state==READY).
REQ-019 In INIT with INIT_ZERO=1, the block SHALL write all-zero words to addresses 0..DEPTH-1, one per cycle in which clocken=1, then enter READY on the cycle after writing DEPTH-1 (fill counter ADDR_WIDTH+1 bits, no wrap).
REQ-020 In INIT with INIT_ZERO=0, the block SHALL enter READY on the first clock edge after reset deasserts.
REQ-021 A write SHALL be accepted when chipselect & write & ~waitrequest & clocken; enabled byte lanes update and disabled lanes are unchanged.
REQ-022 A read SHALL be accepted when chipselect & read & ~write & ~waitrequest & clocken.
REQ-023 For an accepted read, readdata and readdatavalid SHALL appear exactly READ_LATENCY clocken-cycles later; a new read is accepted every cycle (fully pipelined).
REQ-024 When clocken=0, the read pipeline, the fill counter and the array SHALL hold, and readdatavalid SHALL be 0; on resume, the pending data SHALL be presented unchanged.
REQ-025 When read and write are asserted together, only the write SHALL be performed and no readdatavalid SHALL be generated for that cycle.
REQ-026 A read accepted in the cycle after a write to the same address SHALL return the new data, including partial byteenable merges.
REQ-027 An address >= DEPTH SHALL not modify the array on write; a read of such an address SHALL return 0 with a normal readdatavalid.
REQ-028 readdata SHALL hold its last value while readdatavalid=0.
REQ-029 Array contents SHALL be undefined after reset when INIT_ZERO=0, and SHALL be preserved across reset_req.

Reset
REQ-030 While reset=1: state=INIT, fill counter=0, read pipeline cleared, readdata=0, readdatavalid=0, waitrequest=1, init_done=0.
REQ-031 Reset asserted mid-fill or with reads in flight SHALL abort them immediately; in-flight reads SHALL never produce readdatavalid, and the fill SHALL restart from address 0.

Verification
REQ-032 DEPTH=16, INIT_ZERO=1: release reset -> waitrequest=1 for exactly 16 cycles, init_done rises on cycle 17, and reads of addresses 0..15 return 0.
REQ-033 Write 0xAABBCCDD to address 5 with byteenable=1111, then 0x11223344 with byteenable=0101 -> a read of address 5 returns 0xAA22CC44.
REQ-034 READ_LATENCY=2: back-to-back reads of addresses 1,2,3 -> three consecutive readdatavalid pulses starting 2 cycles after the first read, data in order.
REQ-035 Read accepted, then clken=0 for 3 cycles -> readdatavalid is delayed by 3 cycles and the data is correct; with reset_req=1 for 3 cycles -> identical behaviour.
REQ-036 Reset asserted at fill address 9 -> after release, the fill restarts at address 0 and init_done is high after DEPTH cycles.
REQ-037 DEPTH=1000, ADDR_WIDTH=10: write 0xFFFFFFFF to address 1020 -> no array change; a read of address 1020 returns 0 with readdatavalid.
